request_unit_mc: RTL and testbench
==================================

REQUEST_UNIT_MC -- requirements
Module: request_unit_mc

Interface
REQ-001 SHALL have parameter PCSEL_W, default 3: pcstate width, minimum 2.
REQ-002 SHALL have parameter TMO_W, default 8: timeout counter width.
REQ-003 SHALL have parameter CNT_W, default 16: stall performance counter width.
REQ-004 SHALL have parameter ATOMIC_EN, default 1: 1 enables the LL/SC datomic qualifier, 0 ties datomic to 0.
REQ-005 SHALL have CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ihit  input  1  instruction fetch complete this cycle.
REQ-008 SHALL have dhit  input  1  data access complete this cycle.
REQ-009 SHALL have ren, wen  input  1 each  decoded instruction loads / stores.
REQ-010 SHALL have atomic  input  1  decoded instruction is LL (with ren) or SC (with wen).
REQ-011 SHALL have regw  input  1  decoded instruction writes the register file.
REQ-012 SHALL have halt  input  1  decoded instruction is HALT.
REQ-013 SHALL have flush  input  1  restart request from the system.
REQ-014 SHALL have iREN  output  1  instruction read enable.
REQ-015 SHALL have dREN, dWEN  output  1 each  data read / write enable.
REQ-016 SHALL have datomic  output  1  outstanding data access is LL/SC.
REQ-017 SHALL have pcstate  output  PCSEL_W  state code; PC advances only when pcstate==FETCH and ihit is high.
REQ-018 SHALL have stall  output  1  pipeline stalled on data.
REQ-019 SHALL have regwe  output  1  register-file write strobe.
REQ-020 SHALL have timeout  output  1  sticky data-access timeout flag.
REQ-021 SHALL have stallcnt  output  CNT_W  saturating count of DACC cycles.

Function
REQ-022 SHALL implement a three-state FSM with codes FETCH=0, DACC=1, HALTED=2, zero-extended to PCSEL_W and driven on pcstate.
REQ-023 SHALL decode iREN, dREN, dWEN, datomic and stall from registered state only; iREN=1 only in FETCH; stall=1 only in DACC.
REQ-024 In FETCH with ihit=1: halt=1 -> HALTED; else ren|wen=1 -> DACC; else stay in FETCH. halt has priority over ren/wen.
REQ-025 On the FETCH->DACC edge, the unit SHALL latch op type: wen=1 -> write; ren only -> read. wen wins when ren and wen are both 1.
REQ-026 On the FETCH->DACC edge, the unit SHALL latch atomic AND ATOMIC_EN.
REQ-027 In DACC, dREN or dWEN (per latched type) and datomic (per latched atomic) SHALL be held stable every cycle until dhit.
REQ-028 In DACC with dhit=1, next state SHALL be FETCH; dREN/dWEN/datomic are 0 from the following cycle.
REQ-029 Inputs ren/wen/atomic/halt SHALL be ignored outside FETCH&ihit; ihit SHALL be ignored outside FETCH.
REQ-030 regwe SHALL be combinational:
- regw & ihit & ~(ren|wen|halt) in FETCH;
- regw & dhit & latched-read in DACC;
- 0 otherwise.
REQ-031 The timeout counter SHALL clear on entry to DACC and increment each DACC cycle with dhit=0.
REQ-032 When the timeout counter reaches 2^TMO_W-1, the unit SHALL set timeout; the counter holds; the FSM stays in DACC.
REQ-033 timeout SHALL be cleared only by flush or reset.
REQ-034 stallcnt SHALL increment each cycle in DACC, saturate at 2^CNT_W-1, and clear only on reset.
REQ-035 flush in HALTED SHALL move to FETCH next cycle.
REQ-036 flush in FETCH or DACC SHALL only clear timeout; it SHALL NOT abort an outstanding access.
REQ-037 When flush and the timeout-set condition occur in the same cycle, flush SHALL win (timeout=0).
REQ-038 HALTED SHALL be absorbing except for flush: all enables 0, stall=0, regwe=0.

Reset
REQ-039 nRST low SHALL asynchronously force state FETCH, the latched op/atomic, the timeout counter, timeout and stallcnt to 0.
REQ-040 During and after reset, outputs SHALL be iREN=1, dREN=dWEN=datomic=0, pcstate=0, stall=0, timeout=0, stallcnt=0.
REQ-041 Reset asserted mid-DACC SHALL drop dREN/dWEN immediately, without waiting for a clock edge.

Verification
REQ-042 Load: FETCH, ihit=1, ren=1, regw=1; dhit on the 3rd DACC cycle -> dREN=1 for 3 cycles; regwe=1 in the dhit cycle only; stallcnt=3; back to FETCH.
REQ-043 ren=wen=atomic=1 with ihit -> dWEN=1, dREN=0, datomic=1; repeat with ATOMIC_EN=0 -> datomic=0.
REQ-044 TMO_W=3, no dhit -> timeout=1 after 7 DACC cycles, dREN stays 1; flush -> timeout=0 next cycle while state stays DACC.
REQ-045 halt=1 and wen=1 with ihit -> HALTED (pcstate=2), all enables 0; flush -> FETCH, iREN=1.
REQ-046 nRST pulsed low mid-DACC -> dWEN=0 asynchronously, pcstate=0, stallcnt=0; CNT_W=2 run of 5 DACC cycles -> stallcnt saturates at 3.

Source files
------------

// File: rtl/request_unit_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : request_unit_mc_if                                            |
// | Brief    : Handshake bundle between the request unit and its system.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface request_unit_mc_if #(
    parameter int PCSEL_W = 3,
    parameter int CNT_W   = 16
);
    logic               ihit;
    logic               dhit;
    logic               ren;
    logic               wen;
    logic               atomic;
    logic               regw;
    logic               halt;
    logic               flush;
    logic               iREN;
    logic               dREN;
    logic               dWEN;
    logic               datomic;
    logic [PCSEL_W-1:0] pcstate;
    logic               stall;
    logic               regwe;
    logic               timeout;
    logic [CNT_W-1:0]   stallcnt;

    // The request unit issues fetch/data requests, so it takes the master side.
    modport master (
        input  ihit, dhit, ren, wen, atomic, regw, halt, flush,
        output iREN, dREN, dWEN, datomic, pcstate, stall, regwe, timeout, stallcnt
    );

    modport slave (
        output ihit, dhit, ren, wen, atomic, regw, halt, flush,
        input  iREN, dREN, dWEN, datomic, pcstate, stall, regwe, timeout, stallcnt
    );
endinterface
`default_nettype wire

// File: rtl/request_unit_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : request_unit_mc                                               |
// | Brief    : Multicycle fetch/data request sequencer with timeout & stats. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module request_unit_mc #(
    parameter int PCSEL_W   = 3,
    parameter int TMO_W     = 8,
    parameter int CNT_W     = 16,
    parameter int ATOMIC_EN = 1
) (
    input wire                CLK,
    input wire                nRST,
    request_unit_mc_if.master bus
);
    localparam logic [1:0]       c_FETCH    = 2'd0;
    localparam logic [1:0]       c_DACC     = 2'd1;
    localparam logic [1:0]       c_HALTED   = 2'd2;
    localparam logic [TMO_W-1:0] c_TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] c_TMO_LAST = c_TMO_MAX - 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_wr;
    logic             r_atomic;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stallcnt;
    logic             w_in_fetch;
    logic             w_in_dacc;
    logic             w_enter_dacc;
    logic             w_tmo_set;
    logic             w_atomic_in;

    generate
        if (ATOMIC_EN != 0) begin : g_atomic_on
            assign w_atomic_in = bus.atomic;
        end else begin : g_atomic_off
            assign w_atomic_in = 1'b0;
        end
    endgenerate

    assign w_in_fetch   = (r_state == c_FETCH);
    assign w_in_dacc    = (r_state == c_DACC);
    assign w_enter_dacc = w_in_fetch & bus.ihit & ~bus.halt & (bus.ren | bus.wen);
    // Timeout fires on the increment that lands on the terminal count, so a
    // flush while the counter sits at the top does not re-arm the flag.
    assign w_tmo_set    = w_in_dacc & ~bus.dhit & (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FETCH: begin
                if (bus.ihit) begin
                    if (bus.halt)
                        w_state_nxt = c_HALTED;
                    else if (bus.ren | bus.wen)
                        w_state_nxt = c_DACC;
                end
            end
            c_DACC: begin
                if (bus.dhit)
                    w_state_nxt = c_FETCH;
            end
            c_HALTED: begin
                if (bus.flush)
                    w_state_nxt = c_FETCH;
            end
            default: w_state_nxt = c_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= c_FETCH;
            r_wr     <= 1'b0;
            r_atomic <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter_dacc) begin
                r_wr     <= bus.wen;
                r_atomic <= w_atomic_in;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_enter_dacc)
                r_tmo_cnt <= '0;
            else if (w_in_dacc && !bus.dhit && (r_tmo_cnt != c_TMO_MAX))
                r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (bus.flush)
                r_timeout <= 1'b0;
            else if (w_tmo_set)
                r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_stallcnt <= '0;
        else if (w_in_dacc && (r_stallcnt != c_CNT_MAX))
            r_stallcnt <= r_stallcnt + 1'b1;
    end

    // Enables decode from registered state only, so reset drops them at once.
    assign bus.iREN     = w_in_fetch;
    assign bus.dREN     = w_in_dacc & ~r_wr;
    assign bus.dWEN     = w_in_dacc & r_wr;
    assign bus.datomic  = w_in_dacc & r_atomic;
    assign bus.stall    = w_in_dacc;
    assign bus.pcstate  = PCSEL_W'(r_state);
    assign bus.timeout  = r_timeout;
    assign bus.stallcnt = r_stallcnt;
    assign bus.regwe    = (w_in_fetch & bus.regw & bus.ihit & ~(bus.ren | bus.wen | bus.halt))
                        | (w_in_dacc & bus.regw & bus.dhit & ~r_wr);
endmodule
`default_nettype wire

// File: tb/tb_request_unit_mc.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_request_unit_mc                                            |
// | Brief    : Two parameterisations checked against a behavioural model.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_request_unit_mc;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, ren = 1'b0, wen = 1'b0;
    logic atomic = 1'b0, regw = 1'b0, halt = 1'b0, flush = 1'b0;

    always #5 CLK = ~CLK;

    request_unit_mc_if #(.PCSEL_W(3), .CNT_W(2))  bus0 ();
    request_unit_mc_if #(.PCSEL_W(2), .CNT_W(16)) bus1 ();

    assign bus0.ihit = ihit;  assign bus0.dhit = dhit;  assign bus0.ren = ren;    assign bus0.wen = wen;
    assign bus0.atomic = atomic; assign bus0.regw = regw; assign bus0.halt = halt; assign bus0.flush = flush;
    assign bus1.ihit = ihit;  assign bus1.dhit = dhit;  assign bus1.ren = ren;    assign bus1.wen = wen;
    assign bus1.atomic = atomic; assign bus1.regw = regw; assign bus1.halt = halt; assign bus1.flush = flush;

    request_unit_mc #(.PCSEL_W(3), .TMO_W(3), .CNT_W(2), .ATOMIC_EN(1)) u0 (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus0)
    );
    request_unit_mc #(.PCSEL_W(2), .TMO_W(4), .CNT_W(16), .ATOMIC_EN(0)) u1 (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus1)
    );

    // Model: st 0=fetch 1=data access 2=halted; tc counts missed data cycles.
    int m_st[2], m_wr[2], m_at[2], m_tc[2], m_tmo[2], m_sc[2];
    int tmax[2] = '{7, 15};
    int cmax[2] = '{3, 65535};
    int aen[2]  = '{1, 0};
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset(int k);
        m_st[k] = 0; m_wr[k] = 0; m_at[k] = 0; m_tc[k] = 0; m_tmo[k] = 0; m_sc[k] = 0;
    endtask

    task automatic m_step(int k);
        int set;
        set = 0;
        case (m_st[k])
            0: if (ihit) begin
                if (halt) m_st[k] = 2;
                else if (ren || wen) begin
                    m_st[k] = 1;
                    m_wr[k] = int'(wen);
                    m_at[k] = (atomic && aen[k] != 0) ? 1 : 0;
                    m_tc[k] = 0;
                end
            end
            1: begin
                m_sc[k] = (m_sc[k] < cmax[k]) ? m_sc[k] + 1 : cmax[k];
                if (dhit) m_st[k] = 0;
                else if (m_tc[k] < tmax[k]) begin
                    m_tc[k]++;
                    set = (m_tc[k] == tmax[k]) ? 1 : 0;
                end
            end
            default: if (flush) m_st[k] = 0;
        endcase
        m_tmo[k] = flush ? 0 : ((m_tmo[k] != 0 || set != 0) ? 1 : 0);
    endtask

    initial begin
        m_reset(0);
        m_reset(1);
    end

    always @(posedge CLK or negedge nRST) begin
        for (int k = 0; k < 2; k++) begin
            if (!nRST) m_reset(k);
            else       m_step(k);
        end
    end

    task automatic cmp_inst(int k, logic i_r, logic d_r, logic d_w, logic d_a, logic [31:0] pcs,
                            logic stl, logic rwe, logic tmo, logic [31:0] sc);
        int exp_rwe;
        exp_rwe = 0;
        if (m_st[k] == 0) exp_rwe = (regw && ihit && !(ren || wen || halt)) ? 1 : 0;
        if (m_st[k] == 1) exp_rwe = (regw && dhit && m_wr[k] == 0) ? 1 : 0;
        check($sformatf("u%0d.iREN", k),     i_r, (m_st[k] == 0) ? 1 : 0);
        check($sformatf("u%0d.dREN", k),     d_r, (m_st[k] == 1 && m_wr[k] == 0) ? 1 : 0);
        check($sformatf("u%0d.dWEN", k),     d_w, (m_st[k] == 1 && m_wr[k] != 0) ? 1 : 0);
        check($sformatf("u%0d.datomic", k),  d_a, (m_st[k] == 1 && m_at[k] != 0) ? 1 : 0);
        check($sformatf("u%0d.pcstate", k),  pcs, m_st[k]);
        check($sformatf("u%0d.stall", k),    stl, (m_st[k] == 1) ? 1 : 0);
        check($sformatf("u%0d.regwe", k),    rwe, exp_rwe);
        check($sformatf("u%0d.timeout", k),  tmo, m_tmo[k]);
        check($sformatf("u%0d.stallcnt", k), sc,  m_sc[k]);
    endtask

    always @(negedge CLK) begin
        #2;
        if (chk_en) begin
            cmp_inst(0, bus0.iREN, bus0.dREN, bus0.dWEN, bus0.datomic, 32'(bus0.pcstate),
                     bus0.stall, bus0.regwe, bus0.timeout, 32'(bus0.stallcnt));
            cmp_inst(1, bus1.iREN, bus1.dREN, bus1.dWEN, bus1.datomic, 32'(bus1.pcstate),
                     bus1.stall, bus1.regwe, bus1.timeout, 32'(bus1.stallcnt));
        end
    end

    // Inputs change at the falling edge; literal checks follow 3 ns later.
    task automatic drv(bit ih, bit dh, bit r, bit w, bit a, bit rg, bit h, bit f);
        @(negedge CLK);
        ihit = ih; dhit = dh; ren = r; wen = w; atomic = a; regw = rg; halt = h; flush = f;
        #3;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        #3;
        check("rst_iREN", bus0.iREN, 1);
        check("rst_dREN", bus0.dREN, 0);
        check("rst_dWEN", bus0.dWEN, 0);
        check("rst_pcstate", 32'(bus0.pcstate), 0);
        check("rst_stall", bus0.stall, 0);
        check("rst_timeout", bus0.timeout, 0);
        check("rst_stallcnt", 32'(bus0.stallcnt), 0);
        chk_en = 1'b1;
        @(negedge CLK);
        nRST = 1'b1;

        // Load with completion on the third data cycle
        drv(1, 0, 1, 0, 0, 1, 0, 0);
        check("ld_fetch_regwe", bus0.regwe, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        check("ld_c1_dREN", bus0.dREN, 1);
        check("ld_c1_regwe", bus0.regwe, 0);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        check("ld_c2_dREN", bus0.dREN, 1);
        drv(0, 1, 0, 0, 0, 1, 0, 0);
        check("ld_c3_dREN", bus0.dREN, 1);
        check("ld_c3_regwe", bus0.regwe, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("ld_done_pcstate", 32'(bus0.pcstate), 0);
        check("ld_done_dREN", bus0.dREN, 0);
        check("ld_stallcnt0", 32'(bus0.stallcnt), 3);
        check("ld_stallcnt1", 32'(bus1.stallcnt), 3);

        // Two more data cycles: 2-bit counter saturates, wide one reaches 5
        drv(1, 0, 1, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_stallcnt0", 32'(bus0.stallcnt), 3);
        check("sat_stallcnt1", 32'(bus1.stallcnt), 5);

        // Both ren and wen with atomic: write wins, qualifier follows ATOMIC_EN
        drv(1, 0, 1, 1, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("at_dWEN0", bus0.dWEN, 1);
        check("at_dREN0", bus0.dREN, 0);
        check("at_datomic0", bus0.datomic, 1);
        check("at_dWEN1", bus1.dWEN, 1);
        check("at_datomic1", bus1.datomic, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0);

        // Timeout with a 3-bit counter, then flush clears it mid-access
        drv(1, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            drv(0, 0, 0, 0, 0, 0, 0, (c == 8));
            if (c == 7) check("tmo_c7", bus0.timeout, 0);
        end
        check("tmo_c8", bus0.timeout, 1);
        check("tmo_c8_dREN", bus0.dREN, 1);
        check("tmo_u1_clear", bus1.timeout, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("tmo_flushed", bus0.timeout, 0);
        check("tmo_still_dacc", 32'(bus0.pcstate), 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0);

        // Halt beats a store; flush releases
        drv(1, 0, 0, 1, 0, 1, 1, 0);
        check("halt_regwe", bus0.regwe, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("halt_pcstate", 32'(bus0.pcstate), 2);
        check("halt_iREN", bus0.iREN, 0);
        check("halt_dWEN", bus0.dWEN, 0);
        check("halt_stall", bus0.stall, 0);
        drv(1, 1, 1, 1, 0, 1, 0, 1);
        check("halt_absorb_regwe", bus0.regwe, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("unhalt_pcstate", 32'(bus0.pcstate), 0);
        check("unhalt_iREN", bus0.iREN, 1);

        // Asynchronous reset in the middle of a store
        drv(1, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        check("ar_pre_dWEN", bus0.dWEN, 1);
        nRST = 1'b0;
        #1;
        check("ar_dWEN", bus0.dWEN, 0);
        check("ar_pcstate", 32'(bus0.pcstate), 0);
        check("ar_stallcnt0", 32'(bus0.stallcnt), 0);
        check("ar_stallcnt1", 32'(bus1.stallcnt), 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic; the compare process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            ihit   = ($urandom_range(99) < 60);
            dhit   = ($urandom_range(99) < 15);
            ren    = ($urandom_range(99) < 40);
            wen    = ($urandom_range(99) < 30);
            atomic = ($urandom_range(99) < 50);
            regw   = ($urandom_range(99) < 50);
            halt   = ($urandom_range(99) < 5);
            flush  = ($urandom_range(99) < 8);
            nRST   = ($urandom_range(199) != 0);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
